// File: rtl/acc_poll_sequencer_if.sv
`timescale 1ns/1ps
// Command/response handshake between the accelerometer poll sequencer and the
// byte-level I2C engine. "master" is the command issuer.
interface acc_poll_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_nack;

   modport master (output cmd_valid, cmd_op, cmd_wdata,
                   input  cmd_ready, rsp_valid, rsp_rdata, rsp_nack);
   modport slave  (input  cmd_valid, cmd_op, cmd_wdata,
                   output cmd_ready, rsp_valid, rsp_rdata, rsp_nack);
endinterface

// File: rtl/acc_poll_sequencer.sv
`timescale 1ns/1ps
// Configures the accelerometer once, then on every poll tick burst-reads six
// data bytes over the I2C engine and publishes signed X/Y/Z samples.
module acc_poll_sequencer #(
   parameter logic [6:0]  DEV_ADDR = 7'h19,
   parameter logic [7:0]  CTRL_REG = 8'h20,
   parameter logic [7:0]  CTRL_VAL = 8'h57,
   parameter logic [7:0]  DATA_REG = 8'h28,
   parameter int unsigned POLL_DIV = 120000
) (
   input  logic               clk12M,
   input  logic               rst_n,
   acc_poll_if.master         bus,
   output logic signed [15:0] acc_x,
   output logic signed [15:0] acc_y,
   output logic signed [15:0] acc_z,
   output logic               sample_valid,
   output logic               init_done,
   output logic               busy,
   output logic [7:0]         err_cnt
);
   typedef enum logic [2:0] {
      OP_START = 3'd0, OP_RSTART = 3'd1, OP_WRITE = 3'd2,
      OP_READ_ACK = 3'd3, OP_READ_NACK = 3'd4, OP_STOP = 3'd5
   } op_t;

   typedef enum logic [2:0] {
      ST_INIT_WAIT, ST_INIT, ST_IDLE, ST_RD, ST_ERR_STOP
   } state_t;

   typedef struct packed {
      op_t        op;
      logic [7:0] wdata;
   } cmd_t;

   localparam int unsigned   TW        = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(POLL_DIV - 1);
   localparam logic [3:0]    INIT_LAST = 4'd4;
   localparam logic [3:0]    RD_LAST   = 4'd11;

   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic          pending;
   logic          outstanding;
   logic          leave;
   state_t        state;
   logic [3:0]    step;
   logic [3:0]    step_last;
   logic [2:0]    byte_idx;
   logic [7:0]    shadow [6];
   cmd_t          next_cmd;

   // Command script: step k of the init or read transaction.
   function automatic cmd_t cmd_at(input state_t s, input logic [3:0] k);
      cmd_t c;
      c.op    = OP_STOP;
      c.wdata = '0;
      if (s == ST_INIT) begin
         case (k)
            4'd0:    c.op = OP_START;
            4'd1:    begin c.op = OP_WRITE; c.wdata = {DEV_ADDR, 1'b0}; end
            4'd2:    begin c.op = OP_WRITE; c.wdata = CTRL_REG; end
            4'd3:    begin c.op = OP_WRITE; c.wdata = CTRL_VAL; end
            default: c.op = OP_STOP;
         endcase
      end else if (s == ST_RD) begin
         case (k)
            4'd0:                         c.op = OP_START;
            4'd1:                         begin c.op = OP_WRITE; c.wdata = {DEV_ADDR, 1'b0}; end
            4'd2:                         begin c.op = OP_WRITE; c.wdata = DATA_REG | 8'h80; end
            4'd3:                         c.op = OP_RSTART;
            4'd4:                         begin c.op = OP_WRITE; c.wdata = {DEV_ADDR, 1'b1}; end
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9: c.op = OP_READ_ACK;
            4'd10:                        c.op = OP_READ_NACK;
            default:                      c.op = OP_STOP;
         endcase
      end
      return c;
   endfunction

   always_comb begin
      tick      = (tick_cnt == TICK_LAST);
      leave     = ((state == ST_INIT_WAIT) || (state == ST_IDLE)) && pending;
      next_cmd  = cmd_at(state, step + 4'd1);
      step_last = (state == ST_INIT) ? INIT_LAST : (state == ST_RD) ? RD_LAST : '0;
   end

   always_ff @(posedge clk12M or negedge rst_n) begin
      if (!rst_n) tick_cnt <= '0;
      else        tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
   end

   always_ff @(posedge clk12M or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_INIT_WAIT;
         pending       <= 1'b0;
         outstanding   <= 1'b0;
         step          <= '0;
         byte_idx      <= '0;
         bus.cmd_valid <= 1'b0;
         bus.cmd_op    <= '0;
         bus.cmd_wdata <= '0;
         acc_x         <= '0;
         acc_y         <= '0;
         acc_z         <= '0;
         sample_valid  <= 1'b0;
         init_done     <= 1'b0;
         busy          <= 1'b0;
         err_cnt       <= '0;
         for (int unsigned i = 0; i < 6; i++) shadow[i] <= '0;
      end else begin
         sample_valid <= 1'b0;
         // Leaving an idle state consumes the pending tick, even if a new one lands now.
         if (leave)     pending <= 1'b0;
         else if (tick) pending <= 1'b1;

         if (bus.cmd_valid && bus.cmd_ready) begin
            bus.cmd_valid <= 1'b0;
            outstanding   <= 1'b1;
         end

         case (state)
            ST_INIT_WAIT, ST_IDLE: begin
               if (pending) begin
                  state         <= (state == ST_IDLE) ? ST_RD : ST_INIT;
                  step          <= '0;
                  byte_idx      <= '0;
                  busy          <= 1'b1;
                  bus.cmd_valid <= 1'b1;
                  bus.cmd_op    <= OP_START;
                  bus.cmd_wdata <= '0;
               end
            end
            default: begin
               if (bus.rsp_valid && outstanding) begin
                  outstanding <= 1'b0;
                  if (bus.cmd_op == OP_WRITE && bus.rsp_nack) begin
                     state         <= ST_ERR_STOP;
                     step          <= '0;
                     bus.cmd_valid <= 1'b1;
                     bus.cmd_op    <= OP_STOP;
                     bus.cmd_wdata <= '0;
                  end else if (step == step_last) begin
                     busy <= 1'b0;
                     case (state)
                        ST_INIT: begin
                           init_done <= 1'b1;
                           state     <= ST_IDLE;
                        end
                        ST_RD: begin
                           acc_x        <= $signed({shadow[1], shadow[0]});
                           acc_y        <= $signed({shadow[3], shadow[2]});
                           acc_z        <= $signed({shadow[5], shadow[4]});
                           sample_valid <= 1'b1;
                           state        <= ST_IDLE;
                        end
                        default: begin
                           if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                           state <= init_done ? ST_IDLE : ST_INIT_WAIT;
                        end
                     endcase
                  end else begin
                     if (bus.cmd_op == OP_READ_ACK || bus.cmd_op == OP_READ_NACK) begin
                        shadow[byte_idx] <= bus.rsp_rdata;
                        byte_idx         <= byte_idx + 3'd1;
                     end
                     step          <= step + 4'd1;
                     bus.cmd_valid <= 1'b1;
                     bus.cmd_op    <= next_cmd.op;
                     bus.cmd_wdata <= next_cmd.wdata;
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_acc_poll_sequencer.sv
`timescale 1ns/1ps
// Directed bench for acc_poll_sequencer: a small I2C-engine model answers
// commands and logs them; results are compared with hand-computed values.
module tb_acc_poll_sequencer;
   localparam int unsigned POLL_DIV  = 128;
   localparam int          READY_LAT = 1;
   localparam int          RSP_LAT   = 3;

   logic               clk12M = 1'b0;
   logic               rst_n;
   logic signed [15:0] acc_x, acc_y, acc_z;
   logic               sample_valid, init_done, busy;
   logic [7:0]         err_cnt;

   acc_poll_if bus();

   acc_poll_sequencer #(.POLL_DIV(POLL_DIV)) dut (
      .clk12M       (clk12M),
      .rst_n        (rst_n),
      .bus          (bus),
      .acc_x        (acc_x),
      .acc_y        (acc_y),
      .acc_z        (acc_z),
      .sample_valid (sample_valid),
      .init_done    (init_done),
      .busy         (busy),
      .err_cnt      (err_cnt)
   );

   always #5 clk12M = ~clk12M;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Model state: written only by the model, knobs written only by the main sequence.
   logic [10:0] log_q[$];
   logic [7:0]  rd_bytes[6];
   int          rd_resp_cnt = 0;
   int          nack_done   = 0;
   int          nack_total  = 0;
   int          stall_gen   = 0;
   int          stall_len   = 0;
   int          sv_cnt      = 0;

   task automatic check_log(input string tag, input int base, input logic [10:0] exp[$]);
      check({tag, "_len"}, log_q.size() - base, exp.size());
      for (int i = 0; i < exp.size(); i++)
         check($sformatf("%s_%0d", tag, i),
               (base + i < log_q.size()) ? log_q[base + i] : 11'h7FF, exp[i]);
   endtask

   initial begin : bus_model
      int         phase, cnt, lat, stall_seen;
      logic [2:0] op;
      phase = 0; cnt = 0; lat = RSP_LAT; stall_seen = 0; op = '0;
      bus.cmd_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_rdata = '0; bus.rsp_nack = 1'b0;
      forever begin
         @(negedge clk12M);
         bus.cmd_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_rdata = '0; bus.rsp_nack = 1'b0;
         if (rst_n !== 1'b1) phase = 0;
         else case (phase)
            0: if (bus.cmd_valid === 1'b1) begin cnt = 0; phase = 1; end
            1: begin
               cnt++;
               if (cnt >= READY_LAT) begin
                  bus.cmd_ready = 1'b1;
                  op = bus.cmd_op;
                  log_q.push_back({bus.cmd_op, bus.cmd_wdata});
                  phase = 2;
               end
            end
            2: begin
               cnt = 0;
               lat = (stall_seen != stall_gen) ? stall_len : RSP_LAT;
               stall_seen = stall_gen;
               phase = 3;
            end
            default: begin
               cnt++;
               if (cnt >= lat) begin
                  bus.rsp_valid = 1'b1;
                  if (op == 3'd3 || op == 3'd4) begin
                     bus.rsp_rdata = rd_bytes[rd_resp_cnt % 6];
                     rd_resp_cnt++;
                  end else if (op == 3'd2 && nack_done < nack_total) begin
                     bus.rsp_nack = 1'b1;
                     nack_done++;
                  end
                  phase = 0;
               end
            end
         endcase
      end
   end

   always @(negedge clk12M)
      if (rst_n === 1'b1 && sample_valid === 1'b1) sv_cnt++;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int          n, base, sv0, rd0;
      logic [10:0] init_exp[$];
      logic [10:0] rd_exp[$];
      logic [10:0] err_exp[$];
      init_exp = '{{3'd0, 8'h00}, {3'd2, 8'h32}, {3'd2, 8'h20}, {3'd2, 8'h57}, {3'd5, 8'h00}};
      rd_exp   = '{{3'd0, 8'h00}, {3'd2, 8'h32}, {3'd2, 8'hA8}, {3'd1, 8'h00}, {3'd2, 8'h33},
                   {3'd3, 8'h00}, {3'd3, 8'h00}, {3'd3, 8'h00}, {3'd3, 8'h00}, {3'd3, 8'h00},
                   {3'd4, 8'h00}, {3'd5, 8'h00}};
      err_exp  = '{{3'd0, 8'h00}, {3'd2, 8'h32}, {3'd5, 8'h00}};
      rd_bytes = '{8'h10, 8'h02, 8'hF0, 8'hFF, 8'h00, 8'h40};
      rst_n = 1'b0;
      repeat (3) @(negedge clk12M);

      // 1: reset state and init write sequence
      check("rst_cmd_valid", bus.cmd_valid, 0);
      check("rst_cmd_op", bus.cmd_op, 0);
      check("rst_cmd_wdata", bus.cmd_wdata, 0);
      check("rst_init_done", init_done, 0);
      check("rst_busy", busy, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_acc_x", acc_x, 0);
      check("rst_sample_valid", sample_valid, 0);
      base = log_q.size();
      rst_n = 1'b1;
      n = 0;
      while (init_done !== 1'b1 && n < 400) begin @(negedge clk12M); n++; end
      check("init_done", init_done, 1);
      check("init_err_cnt", err_cnt, 0);
      check("init_busy", busy, 0);
      check_log("init_log", base, init_exp);

      // 2: periodic read and sample assembly
      base = log_q.size();
      sv0  = sv_cnt;
      n = 0;
      while (sample_valid !== 1'b1 && n < 400) begin @(negedge clk12M); n++; end
      check("rd_sample_valid", sample_valid, 1);
      check("rd_acc_x", acc_x, 32'h0210);
      check("rd_acc_y", acc_y, -16);
      check("rd_acc_z", acc_z, 32'h4000);
      @(negedge clk12M);
      check("rd_sv_one_cycle", sample_valid, 0);
      check("rd_sv_count", sv_cnt - sv0, 1);
      check_log("rd_log", base, rd_exp);

      // 3: NACK on address during init, then retry on next tick
      rst_n = 1'b0;
      repeat (2) @(negedge clk12M);
      check("rst2_init_done", init_done, 0);
      nack_total = nack_done + 1;
      base = log_q.size();
      rst_n = 1'b1;
      n = 0;
      while (err_cnt !== 8'd1 && n < 400) begin @(negedge clk12M); n++; end
      check("nack_err_cnt", err_cnt, 1);
      check("nack_init_done", init_done, 0);
      check("nack_busy", busy, 0);
      check_log("nack_log", base, err_exp);
      n = 0;
      while (init_done !== 1'b1 && n < 400) begin @(negedge clk12M); n++; end
      check("retry_init_done", init_done, 1);
      check("retry_err_cnt", err_cnt, 1);

      // 4: stalled read spans two ticks; only one extra read follows
      rd_bytes  = '{8'h34, 8'h12, 8'h00, 8'h80, 8'hFF, 8'h7F};
      stall_len = 192;
      stall_gen++;
      sv0 = sv_cnt;
      n = 0;
      while (sample_valid !== 1'b1 && n < 700) begin @(negedge clk12M); n++; end
      check("stall_acc_x", acc_x, 32'h1234);
      check("stall_acc_y", acc_y, -32768);
      check("stall_acc_z", acc_z, 32'h7FFF);
      @(negedge clk12M);
      check("extra_rd_cmd_valid", bus.cmd_valid, 1);
      check("extra_rd_busy", busy, 1);
      n = 0;
      while (sample_valid !== 1'b1 && n < 200) begin @(negedge clk12M); n++; end
      check("extra_rd_sample", sample_valid, 1);
      check("extra_rd_acc_x", acc_x, 32'h1234);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk12M);
         if (bus.cmd_valid === 1'b1 || busy === 1'b1) n++;
      end
      check("surplus_tick_dropped", n, 0);
      check("stall_sv_count", sv_cnt - sv0, 2);

      // 5: reset in the middle of a burst read
      rd0 = rd_resp_cnt;
      sv0 = sv_cnt;
      n = 0;
      while (rd_resp_cnt - rd0 < 3 && n < 400) begin @(negedge clk12M); n++; end
      n = 0;
      while (bus.cmd_valid !== 1'b1 && n < 20) begin @(negedge clk12M); n++; end
      check("mid_cmd_valid", bus.cmd_valid, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_cmd_valid", bus.cmd_valid, 0);
      check("mid_rst_acc_x", acc_x, 0);
      check("mid_rst_acc_y", acc_y, 0);
      check("mid_rst_acc_z", acc_z, 0);
      check("mid_rst_busy", busy, 0);
      repeat (2) @(negedge clk12M);
      rst_n = 1'b1;
      repeat (100) @(negedge clk12M);
      check("mid_rst_no_sample", sv_cnt - sv0, 0);
      check("mid_rst_init_done", init_done, 0);

      // 6: 300 consecutive NACKed init attempts saturate err_cnt
      nack_total = nack_done + 300;
      n = 0;
      while (nack_done < nack_total && n < 300 * POLL_DIV + 500) begin @(negedge clk12M); n++; end
      n = 0;
      while (busy !== 1'b0 && n < 100) begin @(negedge clk12M); n++; end
      check("sat_err_cnt", err_cnt, 255);
      check("sat_init_done", init_done, 0);
      n = 0;
      while (init_done !== 1'b1 && n < 400) begin @(negedge clk12M); n++; end
      check("sat_recover_init_done", init_done, 1);
      check("sat_recover_err_cnt", err_cnt, 255);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
